// File: rtl/result_display_3by3_pkg.sv
// ---------------------------------------------------------------------------
// disp_pkg
// Shared definitions for the 3x3 result display stage: the conversion FSM
// state type, the active-low 7-segment codes ({g,f,e,d,c,b,a}), a BCD
// nibble to segment decoder and the default result width.
// ---------------------------------------------------------------------------
package disp_pkg;

    localparam int DEFAULT_DATA_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    // Non-decimal nibbles never come out of the converter; they map to blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] code;
        case (nibble)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/result_display_3by3_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: DATA_W-bit unsigned in, three BCD
// digits out, one shift per clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load bin_in and clear the BCD digits (takes priority)
//   abort      : drop any conversion in flight
//   bin_in     : unsigned magnitude to convert
//   bcd_out    : {hundreds, tens, ones}; final once the last shift is taken
//   done       : high during the last shift cycle, so bcd_out is final on
//                the following cycle
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] bin_in,
    output logic [11:0]       bcd_out,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W+11:0] sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               active_q, active_d;
    logic [11:0]        adj;

    // Adjust every BCD nibble >= 5 by +3, then shift {bcd, mag} left by one.
    always_comb begin
        adj      = sr_q[DATA_W+11:DATA_W];
        for (int i = 0; i < 3; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done     = 1'b0;
        if (abort) begin
            active_d = 1'b0;
        end else if (start) begin
            sr_d     = {12'd0, bin_in};
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            sr_d  = {adj, sr_q[DATA_W-1:0]} << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                active_d = 1'b0;
                done     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign bcd_out = sr_q[DATA_W+11:DATA_W];

endmodule

// File: rtl/result_display_3by3.sv
// ---------------------------------------------------------------------------
// result_display_3by3
// Shows the signed 3x3 convolution result selected by the controller on a
// 4-digit multiplexed active-low 7-segment display, with one-hot index LEDs.
//   clk, rst_n          : clock, asynchronous active-low reset
//   toggle_3by3         : 1 = show results, 0 = blank and idle
//   buffer_read_addr_in : result index (0=C11, 1=C12, 2=C21, 3=C22)
//   buffer_data         : signed result read at that index
//   seg                 : {g,f,e,d,c,b,a}, active-low
//   an                  : digit enables, active-low one-hot, an[0] rightmost
//   led                 : one-hot of the displayed index
//   busy                : a conversion is in flight
// ---------------------------------------------------------------------------
module result_display_3by3
    import disp_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int REFRESH = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              toggle_3by3,
    input  logic [1:0]        buffer_read_addr_in,
    input  logic [DATA_W-1:0] buffer_data,
    output logic [6:0]        seg,
    output logic [3:0]        an,
    output logic [3:0]        led,
    output logic              busy
);

    localparam int CNT_W = (REFRESH > 1) ? $clog2(REFRESH) : 1;

    state_e              state_q, state_d;
    logic                pending_q, pending_d;
    logic                toggle_prev_q;
    logic [1:0]          addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                sign_q, sign_d;
    logic [1:0]          last_addr_q, last_addr_d;
    logic [DATA_W-1:0]   last_data_q, last_data_d;
    logic                disp_sign_q, disp_sign_d;
    logic [3:0]          disp_hund_q, disp_hund_d;
    logic [3:0]          disp_tens_q, disp_tens_d;
    logic [3:0]          disp_ones_q, disp_ones_d;
    logic [3:0]          led_q, led_d;
    logic                shown_q, shown_d;
    logic [CNT_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic [1:0]          digit_idx_q, digit_idx_d;

    logic                conv_start;
    logic                conv_done;
    logic [11:0]         conv_bcd;
    logic [DATA_W-1:0]   mag;
    logic                trig_idle;
    logic                trig_busy;
    logic [6:0]          digit_seg;

    // |buffer_data| as unsigned; the most negative value maps to its
    // magnitude because the result is reinterpreted as unsigned.
    assign mag = buffer_data[DATA_W-1] ? (~buffer_data + 1'b1) : buffer_data;

    // From IDLE, compare against what is on the display. While converting,
    // compare against the inputs captured for the conversion in flight, so
    // the in-flight value itself does not queue a repeat of itself.
    assign trig_idle = toggle_3by3 &&
                       ((buffer_read_addr_in != last_addr_q) ||
                        (buffer_data != last_data_q) ||
                        !toggle_prev_q);
    assign trig_busy = toggle_3by3 &&
                       ((state_q == ST_SHIFT) || (state_q == ST_COMMIT)) &&
                       ((buffer_read_addr_in != addr_q) ||
                        (buffer_data != data_q));

    bin2bcd_seq #(
        .DATA_W (DATA_W)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (conv_start),
        .abort   (!toggle_3by3),
        .bin_in  (mag),
        .bcd_out (conv_bcd),
        .done    (conv_done)
    );

    // Conversion FSM, pending restart and display register update.
    // Dropping toggle_3by3 overrides everything and aborts to IDLE.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        addr_d      = addr_q;
        data_d      = data_q;
        sign_d      = sign_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        disp_sign_d = disp_sign_q;
        disp_hund_d = disp_hund_q;
        disp_tens_d = disp_tens_q;
        disp_ones_d = disp_ones_q;
        led_d       = led_q;
        shown_d     = shown_q;
        conv_start  = 1'b0;
        if (!toggle_3by3) begin
            state_d   = ST_IDLE;
            pending_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trig_idle) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    conv_start = 1'b1;
                    addr_d     = buffer_read_addr_in;
                    data_d     = buffer_data;
                    sign_d     = buffer_data[DATA_W-1];
                    state_d    = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (trig_busy) begin
                        pending_d = 1'b1;
                    end
                    if (conv_done) begin
                        state_d = ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    disp_sign_d = sign_q;
                    disp_hund_d = conv_bcd[11:8];
                    disp_tens_d = conv_bcd[7:4];
                    disp_ones_d = conv_bcd[3:0];
                    led_d       = 4'b0001 << addr_q;
                    shown_d     = 1'b1;
                    last_addr_d = addr_q;
                    last_data_d = data_q;
                    if (pending_q || trig_busy) begin
                        state_d   = ST_LOAD;
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Free-running scan, independent of the FSM; digit index walks 3,2,1,0.
    always_comb begin
        scan_cnt_d  = scan_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (scan_cnt_q == CNT_W'(REFRESH - 1)) begin
            scan_cnt_d  = '0;
            digit_idx_d = digit_idx_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pending_q     <= 1'b0;
            toggle_prev_q <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            sign_q        <= 1'b0;
            last_addr_q   <= '0;
            last_data_q   <= '0;
            disp_sign_q   <= 1'b0;
            disp_hund_q   <= '0;
            disp_tens_q   <= '0;
            disp_ones_q   <= '0;
            led_q         <= '0;
            shown_q       <= 1'b0;
            scan_cnt_q    <= '0;
            digit_idx_q   <= 2'd3;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            toggle_prev_q <= toggle_3by3;
            addr_q        <= addr_d;
            data_q        <= data_d;
            sign_q        <= sign_d;
            last_addr_q   <= last_addr_d;
            last_data_q   <= last_data_d;
            disp_sign_q   <= disp_sign_d;
            disp_hund_q   <= disp_hund_d;
            disp_tens_q   <= disp_tens_d;
            disp_ones_q   <= disp_ones_d;
            led_q         <= led_d;
            shown_q       <= shown_d;
            scan_cnt_q    <= scan_cnt_d;
            digit_idx_q   <= digit_idx_d;
        end
    end

    // Leading-zero blanking for the selected digit.
    always_comb begin
        case (digit_idx_q)
            2'd3:    digit_seg = disp_sign_q ? SEG_MINUS : SEG_BLANK;
            2'd2:    digit_seg = (disp_hund_q == 4'd0) ? SEG_BLANK
                                                       : bcd_to_seg(disp_hund_q);
            2'd1:    digit_seg = ((disp_hund_q == 4'd0) && (disp_tens_q == 4'd0))
                                 ? SEG_BLANK : bcd_to_seg(disp_tens_q);
            default: digit_seg = bcd_to_seg(disp_ones_q);
        endcase
    end

    // Outputs stay dark until a value has been committed since reset, and
    // whenever the display mode is off.
    always_comb begin
        if (toggle_3by3 && shown_q) begin
            an  = ~(4'b0001 << digit_idx_q);
            seg = digit_seg;
            led = led_q;
        end else begin
            an  = 4'hF;
            seg = SEG_BLANK;
            led = 4'h0;
        end
    end

    assign busy = toggle_3by3 && (state_q != ST_IDLE);

endmodule

// File: tb/tb_result_display_3by3.sv
// ---------------------------------------------------------------------------
// tb_result_display_3by3
// Scenario bench for result_display_3by3 with REFRESH=4, DATA_W=10.
// Expected displays are pushed to a scoreboard queue when a value is driven
// and popped when the conversion completes.
// ---------------------------------------------------------------------------
module tb_result_display_3by3;

    localparam int DATA_W  = 10;
    localparam int REFRESH = 4;

    typedef struct packed {
        logic [3:0][6:0] dig;
        logic [3:0]      led;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              toggle_3by3;
    logic [1:0]        buffer_read_addr_in;
    logic [DATA_W-1:0] buffer_data;
    logic [6:0]        seg;
    logic [3:0]        an;
    logic [3:0]        led;
    logic              busy;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t exp_v;
    logic [6:0] cap_seg [4];
    logic [3:0] cap_led;
    logic [3:0] mid_led;
    int   run_len;

    result_display_3by3 #(
        .DATA_W  (DATA_W),
        .REFRESH (REFRESH)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .toggle_3by3         (toggle_3by3),
        .buffer_read_addr_in (buffer_read_addr_in),
        .buffer_data         (buffer_data),
        .seg                 (seg),
        .an                  (an),
        .led                 (led),
        .busy                (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Independent segment table, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_code(input int n);
        case (n)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;
            3: return 7'h30;  4: return 7'h19;  5: return 7'h12;
            6: return 7'h02;  7: return 7'h78;  8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic exp_t make_exp(input int addr, input int value);
        exp_t e;
        int   a, h, t, o;
        a = (value < 0) ? -value : value;
        h = a / 100;
        t = (a / 10) % 10;
        o = a % 10;
        e.dig[3] = (value < 0) ? 7'h3F : 7'h7F;
        e.dig[2] = (h == 0) ? 7'h7F : seg_code(h);
        e.dig[1] = (h == 0 && t == 0) ? 7'h7F : seg_code(t);
        e.dig[0] = seg_code(o);
        e.led    = 4'b0001 << addr;
        return e;
    endfunction

    // Waits (bounded) for busy to rise, then counts busy cycles. At busy
    // cycle act_at the action act_code is applied: 1 = addr to 1,
    // 2 = drop toggle, 3 = assert reset; codes 2/3 return right away.
    task automatic measure_busy(input int act_at, input int act_code);
        int wait_cnt;
        run_len  = 0;
        wait_cnt = 0;
        @(negedge clk);
        while (!busy && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        while (busy && run_len < 100) begin
            run_len++;
            if (run_len == 18) mid_led = led;
            if (run_len == act_at) begin
                if (act_code == 1) buffer_read_addr_in = 2'd1;
                if (act_code == 2) begin toggle_3by3 = 1'b0; return; end
                if (act_code == 3) begin rst_n = 1'b0; return; end
            end
            @(negedge clk);
        end
    endtask

    // Observes two full scan periods and records each digit's segments.
    task automatic capture_display();
        for (int i = 0; i < 4; i++) cap_seg[i] = 7'bx;
        cap_led = led;
        for (int c = 0; c < 8 * REFRESH; c++) begin
            case (an)
                4'b1110: cap_seg[0] = seg;
                4'b1101: cap_seg[1] = seg;
                4'b1011: cap_seg[2] = seg;
                4'b0111: cap_seg[3] = seg;
                default: ;
            endcase
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        toggle_3by3 = 1'b0;
        buffer_read_addr_in = 2'd0;
        buffer_data = '0;
        #12;
        checks++;
        if ({seg, an, led, busy} !== {7'h7F, 4'hF, 4'h0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_outputs actual=%h/%h/%h/%b required=7f/f/0/0",
                     seg, an, led, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({seg, an, led, busy} !== {7'h7F, 4'hF, 4'h0, 1'b0}) begin
                failures++;
                $display("[TB] FAIL idle_hold cycle=%0d actual=%h/%h/%h/%b required=7f/f/0/0",
                         c, seg, an, led, busy);
            end
        end
    endtask

    task automatic test_positive();
        buffer_read_addr_in = 2'd0;
        buffer_data = 10'd123;
        toggle_3by3 = 1'b1;
        sb.push_back(make_exp(0, 123));
        measure_busy(0, 0);
        checks++;
        if (run_len !== 12) begin
            failures++;
            $display("[TB] FAIL pos_busy_len actual=%0d required=12", run_len);
        end
        capture_display();
        exp_v = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_v.dig[i]) begin
                failures++;
                $display("[TB] FAIL pos_digit%0d actual=%h required=%h", i, cap_seg[i], exp_v.dig[i]);
            end
        end
        checks++;
        if (cap_led !== exp_v.led) begin
            failures++;
            $display("[TB] FAIL pos_led actual=%b required=%b", cap_led, exp_v.led);
        end
    endtask

    task automatic test_negative_min();
        buffer_read_addr_in = 2'd3;
        buffer_data = 10'h200;
        sb.push_back(make_exp(3, -512));
        measure_busy(0, 0);
        checks++;
        if (run_len !== 12) begin
            failures++;
            $display("[TB] FAIL neg_busy_len actual=%0d required=12", run_len);
        end
        capture_display();
        exp_v = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_v.dig[i]) begin
                failures++;
                $display("[TB] FAIL neg_digit%0d actual=%h required=%h", i, cap_seg[i], exp_v.dig[i]);
            end
        end
        checks++;
        if (cap_led !== exp_v.led) begin
            failures++;
            $display("[TB] FAIL neg_led actual=%b required=%b", cap_led, exp_v.led);
        end
    endtask

    task automatic test_zero();
        buffer_data = 10'd0;
        sb.push_back(make_exp(3, 0));
        measure_busy(0, 0);
        checks++;
        if (run_len !== 12) begin
            failures++;
            $display("[TB] FAIL zero_busy_len actual=%0d required=12", run_len);
        end
        capture_display();
        exp_v = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_v.dig[i]) begin
                failures++;
                $display("[TB] FAIL zero_digit%0d actual=%h required=%h", i, cap_seg[i], exp_v.dig[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        buffer_read_addr_in = 2'd0;
        buffer_data = 10'd7;
        sb.push_back(make_exp(0, 7));
        sb.push_back(make_exp(1, 7));
        mid_led = 4'bx;
        measure_busy(4, 1);
        checks++;
        if (run_len !== 24) begin
            failures++;
            $display("[TB] FAIL b2b_busy_len actual=%0d required=24", run_len);
        end
        exp_v = sb.pop_front();
        checks++;
        if (mid_led !== exp_v.led) begin
            failures++;
            $display("[TB] FAIL b2b_first_led actual=%b required=%b", mid_led, exp_v.led);
        end
        capture_display();
        exp_v = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_v.dig[i]) begin
                failures++;
                $display("[TB] FAIL b2b_digit%0d actual=%h required=%h", i, cap_seg[i], exp_v.dig[i]);
            end
        end
        checks++;
        if (cap_led !== exp_v.led) begin
            failures++;
            $display("[TB] FAIL b2b_led actual=%b required=%b", cap_led, exp_v.led);
        end
    endtask

    task automatic test_toggle_abort();
        buffer_read_addr_in = 2'd2;
        buffer_data = 10'(-45);
        measure_busy(5, 2);
        #1;
        checks++;
        if ({seg, an, led, busy} !== {7'h7F, 4'hF, 4'h0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL abort_blank actual=%h/%h/%h/%b required=7f/f/0/0",
                     seg, an, led, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_idle actual=%b required=0", busy);
        end
        toggle_3by3 = 1'b1;
        sb.push_back(make_exp(2, -45));
        measure_busy(0, 0);
        checks++;
        if (run_len !== 12) begin
            failures++;
            $display("[TB] FAIL abort_rerun_len actual=%0d required=12", run_len);
        end
        capture_display();
        exp_v = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_v.dig[i]) begin
                failures++;
                $display("[TB] FAIL abort_digit%0d actual=%h required=%h", i, cap_seg[i], exp_v.dig[i]);
            end
        end
        checks++;
        if (cap_led !== exp_v.led) begin
            failures++;
            $display("[TB] FAIL abort_led actual=%b required=%b", cap_led, exp_v.led);
        end
    endtask

    task automatic test_reset_mid_shift();
        buffer_read_addr_in = 2'd1;
        buffer_data = 10'd99;
        measure_busy(5, 3);
        #1;
        checks++;
        if ({seg, an, led, busy} !== {7'h7F, 4'hF, 4'h0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL rst_mid_blank actual=%h/%h/%h/%b required=7f/f/0/0",
                     seg, an, led, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(make_exp(1, 99));
        measure_busy(0, 0);
        checks++;
        if (run_len !== 12) begin
            failures++;
            $display("[TB] FAIL rst_rerun_len actual=%0d required=12", run_len);
        end
        capture_display();
        exp_v = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_v.dig[i]) begin
                failures++;
                $display("[TB] FAIL rst_digit%0d actual=%h required=%h", i, cap_seg[i], exp_v.dig[i]);
            end
        end
        checks++;
        if (cap_led !== exp_v.led) begin
            failures++;
            $display("[TB] FAIL rst_led actual=%b required=%b", cap_led, exp_v.led);
        end
    endtask

    task automatic test_rising_edge();
        int spurious;
        // Same inputs as committed: only the toggle edge should retrigger.
        spurious = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            failures++;
            $display("[TB] FAIL no_retrigger actual=%0d busy cycles required=0", spurious);
        end
        toggle_3by3 = 1'b0;
        repeat (4) @(negedge clk);
        toggle_3by3 = 1'b1;
        sb.push_back(make_exp(1, 99));
        measure_busy(0, 0);
        checks++;
        if (run_len !== 12) begin
            failures++;
            $display("[TB] FAIL edge_busy_len actual=%0d required=12", run_len);
        end
        capture_display();
        exp_v = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_seg[i] !== exp_v.dig[i]) begin
                failures++;
                $display("[TB] FAIL edge_digit%0d actual=%h required=%h", i, cap_seg[i], exp_v.dig[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_positive();
        test_negative_min();
        test_zero();
        test_back_to_back();
        test_toggle_abort();
        test_reset_mid_shift();
        test_rising_edge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
